// File: rtl/apb_master_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_master_arb: round-robin arbiter sharing one APB master port   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module apb_master_arb #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_grant_found;
  logic             w_accept;
  logic             w_done;
  logic             w_timeout;
  logic [CNT_W-1:0] r_wait_cnt;
  int               w_idx;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_grant_idx   = r_rr_ptr;
    w_grant_found = 1'b0;
    w_idx         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_grant_found && req_valid[w_idx]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = IDX_W'(w_idx);
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // The IDLE cycle carrying rsp_valid never grants, forcing one PSEL-low gap.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_found && (rsp_valid == '0)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if ((TIMEOUT != 0) && (r_wait_cnt == C_CNT_LAST)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign req_ready = (w_accept && PRESETn) ? (N_REQ'(1) << w_grant_idx) : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_wait_cnt <= '0;
    end else begin
      rsp_valid <= '0;
      if (w_accept) begin
        PSEL       <= 1'b1;
        PWRITE     <= req_write[w_grant_idx];
        PADDR      <= req_addr[w_grant_idx*ADDR_W +: ADDR_W];
        PWDATA     <= req_wdata[w_grant_idx*DATA_W +: DATA_W];
        r_grant    <= w_grant_idx;
        r_wait_cnt <= '0;
      end
      if (r_state == S_SETUP) PENABLE <= 1'b1;
      if ((r_state == S_ACCESS) && !PREADY && (r_wait_cnt != C_CNT_MAX))
        r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_done || w_timeout) begin
        PSEL      <= 1'b0;
        PENABLE   <= 1'b0;
        rsp_valid <= N_REQ'(1) << r_grant;
        rsp_err   <= w_timeout | PSLVERR;
        rsp_rdata <= (w_timeout || PWRITE || PSLVERR) ? '0 : PRDATA;
        r_rr_ptr  <= (r_grant == C_LAST_IDX) ? '0 : r_grant + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arb.sv
`default_nettype none
// Randomized scoreboard bench for apb_master_arb with a transaction-level
// arbitration/timing model and a behavioural APB completer.
module tb_apb_master_arb;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            PCLK = 1'b0;
  logic            PRESETn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata, PWDATA;
  logic [DW-1:0]   PRDATA = '0;
  logic            rsp_err, PSEL, PENABLE, PWRITE;
  logic            PREADY = 1'b0;
  logic            PSLVERR = 1'b0;
  logic [AW-1:0]   PADDR;

  apb_master_arb #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        err;
  } cmd_t;
  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  cmd_t rq [N][$];
  cmd_t apb_exp[$];
  rsp_t rsp_exp[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  int   ptr = 0, next_free = 0, act_setup = 0, act_rsp = 0;
  logic [N-1:0] popped = '0;
  cmd_t cur;
  int   acc_k = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  always_ff @(posedge PCLK) if (PRESETn) cyc <= cyc + 1;

  // Arbitration/timing model plus requester driver.
  always begin : model_drv
    cmd_t c;
    rsp_t r;
    int g, idx;
    logic [N-1:0] er;
    logic tmo;
    @(negedge PCLK);
    if (!PRESETn) begin
      ptr = 0; next_free = 0; act_setup = 0; act_rsp = 0; popped = '0;
    end else begin
      chk("psel", PSEL, (cyc >= act_setup) && (cyc < act_rsp));
      chk("penable", PENABLE, (cyc > act_setup) && (cyc < act_rsp));
      g = -1;
      if (cyc >= next_free)
        for (int k = 0; k < N; k++) begin
          idx = (ptr + k) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", req_ready, er);
      if (g >= 0 && rq[g].size() > 0) begin
        c   = rq[g][0];
        tmo = (TO > 0) && (c.waits >= TO);
        act_setup = cyc + 1;
        act_rsp   = tmo ? cyc + 2 + TO : cyc + 3 + c.waits;
        next_free = act_rsp + 1;
        ptr = (g + 1) % N;
        r.idx = g; r.err = tmo || c.err; r.cyc = act_rsp;
        r.rdata = (tmo || c.wr || c.err) ? 32'h0 : c.rdata;
        apb_exp.push_back(c);
        rsp_exp.push_back(r);
      end
      for (int i = 0; i < N; i++)
        if (req_ready[i]) begin
          if (rq[i].size() > 0) void'(rq[i].pop_front());
          popped[i] = 1'b1;
        end
    end
    @(posedge PCLK);
    #1;
    if (!PRESETn) req_valid = '0;
    else for (int i = 0; i < N; i++) begin
      if (popped[i]) begin popped[i] = 1'b0; req_valid[i] = 1'b0; end
      if (!req_valid[i] && rq[i].size() > 0 && $urandom_range(0, 3) != 0) begin
        c = rq[i][0];
        req_valid[i] = 1'b1;
        req_write[i] = c.wr;
        req_addr[i*AW +: AW]  = c.addr;
        req_wdata[i*DW +: DW] = c.wdata;
      end
    end
  end

  // APB completer: wait states, data and error taken from the transfer it serves.
  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (PSEL && !PENABLE) begin
        if (apb_exp.size() == 0) fail_now("apb_setup_unexpected");
        else begin
          cur = apb_exp.pop_front();
          chk("paddr", PADDR, cur.addr);
          chk("pwrite", PWRITE, cur.wr);
          chk("pwdata", PWDATA, cur.wdata);
        end
        acc_k   = 0;
        PREADY  = 1'($urandom_range(0, 1));
        PSLVERR = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
      end else if (PSEL && PENABLE) begin
        chk("paddr_hold", PADDR, cur.addr);
        chk("pwdata_hold", PWDATA, cur.wdata);
        PREADY  = (acc_k >= cur.waits);
        acc_k++;
        PRDATA  = PREADY ? cur.rdata : $urandom;
        PSLVERR = PREADY ? cur.err : 1'($urandom_range(0, 1));
      end else begin
        PREADY  = 1'($urandom_range(0, 1));
        PSLVERR = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
      end
    end
  end

  // Response monitor.
  always @(negedge PCLK) begin
    rsp_t r;
    if (!PRESETn) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
    end else if (rsp_valid != '0) begin
      if (rsp_exp.size() == 0) fail_now("rsp_unexpected");
      else begin
        r = rsp_exp.pop_front();
        chk("rsp_valid", rsp_valid, 64'd1 << r.idx);
        chk("rsp_rdata", rsp_rdata, r.rdata);
        chk("rsp_err", rsp_err, r.err);
        chk("rsp_cycle", cyc, r.cyc);
      end
    end
  end

  task automatic push(input int i, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int w, input logic e);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = wd; c.rdata = rd; c.waits = w; c.err = e;
    rq[i].push_back(c);
  endtask

  function automatic bit busy();
    bit b = (rsp_exp.size() > 0);
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input int budget);
    int t = 0;
    while (busy() && t < budget) begin @(negedge PCLK); t++; end
    if (t >= budget) fail_now("drain_timeout");
    repeat (2) @(negedge PCLK);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge PCLK);
    chk("reset_psel", PSEL, 0);
    chk("reset_penable", PENABLE, 0);
    chk("reset_pwrite", PWRITE, 0);
    chk("reset_paddr", PADDR, 0);
    chk("reset_pwdata", PWDATA, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    #2 PRESETn = 1'b1;

    push(0, 1'b1, 32'h10, 32'hA5A5_0001, 32'h0, 0, 1'b0);
    drain(100);
    push(1, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
    drain(100);
    for (int j = 0; j < 2; j++) begin
      push(0, 1'b1, 32'h100 + j, $urandom, 32'h0, 0, 1'b0);
      push(1, 1'b0, 32'h200 + j, 32'h0, $urandom, 0, 1'b0);
    end
    drain(200);
    push(0, 1'b0, 32'h30, 32'h0, 32'h1234_5678, 1, 1'b1);
    drain(100);
    push(1, 1'b0, 32'h40, 32'h0, 32'h5555_AAAA, 7, 1'b0);
    push(1, 1'b1, 32'h44, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
    drain(200);

    // Reset while the completer is inserting wait states.
    push(2, 1'b0, 32'h50, 32'h0, 32'h0BAD_0BAD, 3, 1'b0);
    t = 0;
    while (!(PSEL && PENABLE) && t < 100) begin @(negedge PCLK); t++; end
    if (t >= 100) fail_now("wait_access_timeout");
    #2 PRESETn = 1'b0;
    #1;
    chk("midrst_psel", PSEL, 0);
    chk("midrst_penable", PENABLE, 0);
    for (int i = 0; i < N; i++) rq[i].delete();
    apb_exp.delete();
    rsp_exp.delete();
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1'b1;
    push(1, 1'b1, 32'h60, 32'h1357_9BDF, 32'h0, 0, 1'b0);
    push(1, 1'b0, 32'h64, 32'h0, 32'h2468_ACE0, 2, 1'b0);
    drain(200);

    for (int j = 0; j < 150; j++)
      push($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
           $urandom_range(0, 6), ($urandom_range(0, 7) == 0));
    drain(20000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
